// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences sample capture into the channel RAMqueues.
// Drives the shared write enable/address, arms once enough pre-trigger samples
// are stored, counts post-trigger samples, then pulses set_capture_done and
// reports the address of the oldest stored sample.
//
// Handshake: wrt_smpl is a one-cycle strobe with no back-pressure; a sample is
// written exactly on the cycles where we is high. set_capture_done is a
// one-cycle pulse; capture_done is the level held by cmd_cfg until the host
// clears it, and a new capture only starts once it is low.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            capture_done,
    input  logic            wrt_smpl,
    input  logic            triggered,
    input  logic [LOG2-1:0] trig_pos,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic            armed,
    output logic            set_capture_done,
    output logic [LOG2-1:0] ram_addr,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Sample counter is one bit wider so it can hold ENTRIES itself.
    localparam int CW = LOG2 + 1;
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
    localparam logic [CW-1:0]   FULL = CW'(ENTRIES);

    state_t          state;
    logic [CW-1:0]   smpl_cnt;
    logic [LOG2-1:0] post_cnt;

    logic [LOG2-1:0] trig_pos_c;
    logic [CW-1:0]   pre_target;
    logic [LOG2-1:0] waddr_nxt;
    logic [LOG2-1:0] waddr_after;
    logic            post_last;

    // Clamp the post-trigger count so at least one pre-trigger sample is kept,
    // and derive the write-side helpers from the current registered state.
    always_comb begin
        trig_pos_c  = (trig_pos > LAST) ? LAST : trig_pos;
        pre_target  = FULL - {1'b0, trig_pos_c};
        we          = wrt_smpl && ((state == CAPTURE) || (state == POST));
        armed       = (state == CAPTURE) && (smpl_cnt >= pre_target);
        waddr_nxt   = (waddr == LAST) ? '0 : waddr + 1'b1;
        waddr_after = we ? waddr_nxt : waddr;
        // >= keeps POST from running forever if trig_pos is lowered mid-capture.
        post_last   = ({1'b0, post_cnt} + 1'b1) >= {1'b0, trig_pos_c};
    end

    assign state_dbg = state;

    // Capture state machine, write address, counters and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            waddr            <= '0;
            smpl_cnt         <= '0;
            post_cnt         <= '0;
            ram_addr         <= '0;
            set_capture_done <= 1'b0;
        end else begin
            set_capture_done <= 1'b0;
            if (we) begin
                waddr <= waddr_nxt;
            end
            case (state)
                IDLE: begin
                    // Undumped data is protected while capture_done is still set.
                    if (run && !capture_done) begin
                        state    <= CAPTURE;
                        waddr    <= '0;
                        smpl_cnt <= '0;
                        post_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    if (!run) begin
                        state <= IDLE;
                    end else begin
                        if (we && (smpl_cnt != FULL)) begin
                            smpl_cnt <= smpl_cnt + 1'b1;
                        end
                        // A sample written in the trigger cycle is pre-trigger.
                        if (triggered && armed) begin
                            if (trig_pos_c == '0) begin
                                state            <= DONE;
                                set_capture_done <= 1'b1;
                                ram_addr         <= waddr_after;
                            end else begin
                                state <= POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (we) begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_last) begin
                            state            <= DONE;
                            set_capture_done <= 1'b1;
                            ram_addr         <= waddr_nxt;
                        end
                    end
                end
                DONE: begin
                    if (!capture_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
